// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_e     : controller states (IDLE / CMP / DONE)
//   RES_*       : encoding of the running compare result
//   num_chunks  : number of compare steps for a given operand and chunk width
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } state_e;

  // RES_EQ doubles as "equal so far" while the compare is in progress.
  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_LT = 2'b01;
  localparam logic [1:0] RES_GT = 2'b10;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one chunk.
//   a_i, b_i : chunk operands
//   lt_o     : a_i < b_i
//   gt_o     : a_i > b_i
module chunk_compare #(
  parameter int unsigned Width = 3
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             lt_o,
  output logic             gt_o
);

  assign lt_o = (a_i < b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Operands arrive on a valid/ready handshake and are
// compared CHUNK bits per cycle, MSB chunk first; the one-hot result leaves on a second
// valid/ready handshake.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid / in_ready    : operand handshake (a, b, is_signed sampled on accept)
//   out_valid / out_ready  : result handshake
//   lesser/greater/equal   : one-hot result, all zero while out_valid is low
// Optional build macro SEQ_CMP_EARLY_EXIT_EN: finish as soon as a chunk differs instead of
// always walking all NCHUNK chunks.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lesser,
  output logic             greater,
  output logic             equal
);

  localparam int unsigned NCHUNK = num_chunks(WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       res_q, res_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_lt, chunk_gt;
  logic             accept;
  logic [WIDTH-1:0] sign_flip;

  assign accept = in_valid && in_ready;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_flip = {is_signed, {(WIDTH - 1){1'b0}}};

  assign a_chunk = a_q[idx_q * CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q * CHUNK +: CHUNK];

  chunk_compare #(
    .Width (CHUNK)
  ) u_chunk_compare (
    .a_i  (a_chunk),
    .b_i  (b_chunk),
    .lt_o (chunk_lt),
    .gt_o (chunk_gt)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= RES_EQ;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CMP;
      CMP: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
        if (idx_q == '0 || (res_q == RES_EQ && (chunk_lt || chunk_gt))) state_d = DONE;
`else
        if (idx_q == '0) state_d = DONE;
`endif
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    res_d = res_q;
    if (state_q == IDLE && accept) begin
      a_d   = PW'(a ^ sign_flip);
      b_d   = PW'(b ^ sign_flip);
      idx_d = IW'(NCHUNK - 1);
      res_d = RES_EQ;
    end else if (state_q == CMP) begin
      // First differing chunk decides; later chunks cannot override it.
      if (res_q == RES_EQ) begin
        if (chunk_lt) res_d = RES_LT;
        else if (chunk_gt) res_d = RES_GT;
      end
      if (idx_q != '0) idx_d = idx_q - 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    lesser    = out_valid && (res_q == RES_LT);
    greater   = out_valid && (res_q == RES_GT);
    equal     = out_valid && (res_q == RES_EQ);
  end

endmodule
